fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage between the program counter and the decode stage. Each cycle it may sample the current PC, issue a request to instruction memory over a req/ack handshake, and present the returned word with its address in the IF/ID register. A one-entry skid buffer absorbs a response that arrives while decode is stalled. `pc_stall` back-pressures the PC, and `flush` discards in-flight and buffered instructions on a redirect.

## Interface
- WIDTH, 32, address width (pc, mem_addr, if_pc)
- ILEN, 32, instruction width
- NOP, 32'h0000_0013, value driven on if_instr when the IF/ID register is empty after reset or flush
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- pc_in  in  WIDTH  current PC value, sampled on launch
- pc_stall  out  1  combinational; 1 = PC must hold this cycle (no launch). PC redirects override it.
- mem_req  out  1  memory request, registered
- mem_addr  out  WIDTH  request address, registered, stable while mem_req=1
- mem_ack  in  1  response valid; mem_rdata is valid in the same cycle
- mem_rdata  in  ILEN  instruction word
- id_stall  in  1  decode cannot consume the IF/ID register this cycle
- flush  in  1  redirect; kill everything younger than decode
- if_valid  out  1  IF/ID register holds a valid instruction
- if_instr  out  ILEN  IF/ID instruction
- if_pc  out  WIDTH  address of if_instr

## Operation
- States: S_IDLE (no request outstanding), S_REQ (mem_req=1, waiting for ack), S_DISCARD (request outstanding, response to be dropped).
- consume = if_valid & ~id_stall. ID-ready = ~if_valid | ~id_stall.
- Response routing on an accepted ack in S_REQ:
  - If skid is empty and ID-ready: load IF/ID with {rdata, mem_addr}.
  - Otherwise: load skid.
- Skid drain: if skid is valid and ID-ready, IF/ID <= skid and skid becomes empty. Skid data takes precedence; a simultaneous ack then goes to skid.
- launch loads mem_addr <= pc_in, sets mem_req=1 next cycle, and gives pc_stall=0.
- Launch conditions:
  - S_IDLE: launch when the skid will be empty at the end of the cycle.
  - S_REQ with ack: launch (stay S_REQ) when the response goes to IF/ID and the skid is empty. Otherwise go to S_IDLE.
  - S_REQ without ack: no launch.
- The skid must never be written while full. The launch rule guarantees this; an assertion checks it.
- flush (priority over everything except rst):
  - Clears if_valid and the skid valid; if_instr <= NOP.
  - No launch; pc_stall=1.
  - S_REQ without ack goes to S_DISCARD. S_REQ with ack drops the data and goes to S_IDLE.
- S_DISCARD: keeps mem_req and mem_addr, ignores rdata, goes to S_IDLE on ack. A flush while in S_DISCARD stays in S_DISCARD.
- mem_ack while mem_req=0 (S_IDLE) is ignored.
- id_stall with if_valid=0 has no effect.

## Timing
- Reset (rst=0 at an edge): state S_IDLE, mem_req=0, mem_addr=0, if_valid=0, if_instr=NOP, if_pc=0, skid empty. pc_stall=1 while rst=0.
- Latency: launch at cycle N gives mem_req at N+1. With ack at N+1+k (k≥0 wait states), if_valid=1 at N+2+k.
- Zero-wait memory and no stalls: one instruction per cycle after a 2-cycle fill. if_pc sequence equals the pc_in sequence at the launch cycles.
- mem_req deasserts only in the cycle after an ack with no launch, or on reset. mem_addr changes only on launch.
- Reset mid-request: mem_req drops the next cycle. Any late ack is ignored because the state is S_IDLE.
- The decode handshake is fully registered; if_* change only on edges.

## Test plan
- Zero-wait stream: pc_in 0,4,8,C with ack whenever mem_req=1 -> if_pc 0,4,8,C on consecutive cycles starting at cycle 2. pc_stall=0 every cycle after reset.
- Wait states: ack 3 cycles after each mem_req rise -> pc_stall=1 during waits. Each instruction appears in IF/ID with if_pc incrementing by 4, and none are lost or duplicated.
- Decode stall: id_stall=1 for 4 cycles mid-stream -> the pending response lands in skid and pc_stall=1 until it drains. On release, the order is preserved (e.g. 8 then C).
- Flush with outstanding request: flush in a cycle with mem_req=1, ack two cycles later with rdata=DEADBEEF -> DEADBEEF is never shown and if_valid=0. The next launch uses pc_in = redirect target (e.g. 0x40), and if_pc=0x40.
- Flush coincident with ack and a full skid -> if_valid=0, skid empty, if_instr=NOP the next cycle, state S_IDLE.
- Reset mid-request: rst=0 for 1 cycle while waiting, ack arrives after -> all outputs at reset values and the late ack is ignored. Fetch restarts from pc_in.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: launches memory requests from the PC, holds the
// returned word in the IF/ID register, and uses a one-entry skid buffer when decode stalls.
module fetch_stage #(
   parameter int              WIDTH = 32,
   parameter int              ILEN  = 32,
   parameter logic [ILEN-1:0] NOP   = 32'h0000_0013
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pc_in,
   output logic             pc_stall,
   output logic             mem_req,
   output logic [WIDTH-1:0] mem_addr,
   input  logic             mem_ack,
   input  logic [ILEN-1:0]  mem_rdata,
   input  logic             id_stall,
   input  logic             flush,
   output logic             if_valid,
   output logic [ILEN-1:0]  if_instr,
   output logic [WIDTH-1:0] if_pc
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DISCARD} state_t;

   state_t           state, state_nxt;
   logic             skid_valid;
   logic [ILEN-1:0]  skid_instr;
   logic [WIDTH-1:0] skid_pc;

   logic id_ready, ack_live, skid_drain, resp_to_id, resp_to_skid;
   logic launch_ok, launch;

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      launch    = 1'b0;
      state_nxt = state;

      id_ready     = ~if_valid | ~id_stall;
      ack_live     = (state == S_REQ) & mem_ack;
      skid_drain   = skid_valid & id_ready;
      resp_to_id   = ack_live & ~skid_valid & id_ready;
      resp_to_skid = ack_live & ~resp_to_id;
      launch_ok    = rst & ~flush;

      case (state)
         S_IDLE: begin
            launch = launch_ok & (~skid_valid | skid_drain);
            if (launch) state_nxt = S_REQ;
         end
         S_REQ: begin
            if (flush) begin
               state_nxt = mem_ack ? S_IDLE : S_DISCARD;
            end else if (mem_ack) begin
               // Only relaunch when the skid stays empty, so it can never overflow.
               launch    = launch_ok & resp_to_id;
               state_nxt = launch ? S_REQ : S_IDLE;
            end
         end
         S_DISCARD: begin
            if (mem_ack) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign pc_stall = ~launch;

   always_ff @(posedge clk) begin
      if (!rst) begin
         // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
         state      <= S_IDLE;
         mem_req    <= 1'b0;
         mem_addr   <= '0;
         if_valid   <= 1'b0;
         if_instr   <= NOP;
         if_pc      <= '0;
         skid_valid <= 1'b0;
      end else begin
         state   <= state_nxt;
         mem_req <= (state_nxt != S_IDLE);
         if (launch) mem_addr <= pc_in;

         if (flush) begin
            if_valid   <= 1'b0;
            if_instr   <= NOP;
            skid_valid <= 1'b0;
         end else begin
            if (skid_drain) begin
               if_valid <= 1'b1;
               if_instr <= skid_instr;
               if_pc    <= skid_pc;
            end else if (resp_to_id) begin
               if_valid <= 1'b1;
               if_instr <= mem_rdata;
               if_pc    <= mem_addr;
            end else if (if_valid & ~id_stall) begin
               if_valid <= 1'b0;
            end

            if (resp_to_skid)    skid_valid <= 1'b1;
            else if (skid_drain) skid_valid <= 1'b0;
         end
      end
   end

   // NOTE: skid payload is qualified by skid_valid, so it needs no reset.
   always_ff @(posedge clk) begin
      if (resp_to_skid & ~flush) begin
         skid_instr <= mem_rdata;
         skid_pc    <= mem_addr;
      end
   end

   a_skid_no_overwrite : assert property (@(posedge clk) disable iff (!rst)
      (resp_to_skid & ~flush) |-> (~skid_valid | skid_drain));

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a queue-level model predicts every output
// each cycle, with directed scenarios and hand-computed literal pins.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] pc_in = '0;
   logic        pc_stall;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        id_stall = 1'b0;
   logic        flush = 1'b0;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk      (clk),
      .rst      (rst),
      .pc_in    (pc_in),
      .pc_stall (pc_stall),
      .mem_req  (mem_req),
      .mem_addr (mem_addr),
      .mem_ack  (mem_ack),
      .mem_rdata(mem_rdata),
      .id_stall (id_stall),
      .flush    (flush),
      .if_valid (if_valid),
      .if_instr (if_instr),
      .if_pc    (if_pc)
   );

   // Model: fetched words waiting for decode (front = IF/ID) plus the outstanding request.
   typedef struct {logic [31:0] instr; logic [31:0] pc;} ent_t;
   typedef enum {R_NONE, R_LIVE, R_DEAD} req_e;

   ent_t        q[$];
   req_e        m_req = R_NONE;
   logic [31:0] m_addr = '0;
   logic [31:0] m_disp_instr = NOP;
   logic [31:0] m_disp_pc = '0;
   int          m_age = 0;
   bit          m_known = 0;

   bit          auto_mem = 0;
   bit          auto_pc = 1;
   int          ack_wait = 0;
   logic [31:0] next_pc = '0;
   logic [31:0] seen_pc[$];
   bit          saw_deadbeef = 0;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return 32'hC0DE_0000 | {16'h0000, a[15:0]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // A new fetch may start only when no live request remains and at most one word is held at cycle end.
   function automatic bit model_launch();
      int occ;
      if (!rst || flush) return 0;
      if (m_req == R_DEAD) return 0;
      if (m_req == R_LIVE && !mem_ack) return 0;
      occ = q.size();
      if (occ > 0 && !id_stall) occ--;
      if (m_req == R_LIVE) occ++;
      return occ <= 1;
   endfunction

   task automatic model_update(input bit launch);
      ent_t e;
      if (!rst) begin
         q.delete();
         m_req = R_NONE; m_addr = '0; m_age = 0;
         m_disp_instr = NOP; m_disp_pc = '0;
         m_known = 1;
         return;
      end
      if (flush) begin
         q.delete();
         m_disp_instr = NOP;
         if (m_req == R_LIVE) m_req = mem_ack ? R_NONE : R_DEAD;
         else if (m_req == R_DEAD && mem_ack) m_req = R_NONE;
         if (m_req != R_NONE) m_age++;
         return;
      end
      if (q.size() > 0 && !id_stall) void'(q.pop_front());
      if (m_req == R_LIVE && mem_ack) begin
         e.instr = mem_rdata;
         e.pc    = m_addr;
         q.push_back(e);
      end
      if (m_req != R_NONE && mem_ack) m_req = R_NONE;
      if (launch) begin
         m_req = R_LIVE; m_addr = pc_in; m_age = 0;
         if (auto_pc) next_pc += 4;
      end else if (m_req != R_NONE) begin
         m_age++;
      end
      if (q.size() > 0) begin
         m_disp_instr = q[0].instr;
         m_disp_pc    = q[0].pc;
      end
   endtask

   // One clock: apply inputs, compare every output against the model, advance the model.
   task automatic tick();
      bit launch;
      if (auto_pc) pc_in = next_pc;
      if (auto_mem) begin
         mem_ack   = (m_req != R_NONE) && (m_age >= ack_wait);
         mem_rdata = instr_of(m_addr);
      end
      #1;
      launch = model_launch();
      if (m_known) begin
         check("pc_stall", pc_stall, !launch);
         check("mem_req", mem_req, m_req != R_NONE);
         check("mem_addr", mem_addr, m_addr);
         check("if_valid", if_valid, q.size() > 0);
         check("if_instr", if_instr, m_disp_instr);
         check("if_pc", if_pc, m_disp_pc);
         if (if_valid && !id_stall) seen_pc.push_back(if_pc);
         if (if_valid && if_instr == 32'hDEAD_BEEF) saw_deadbeef = 1;
      end
      @(posedge clk);
      model_update(launch);
      @(negedge clk);
   endtask

   initial begin
      // Reset
      rst = 1'b0; auto_mem = 1; ack_wait = 0;
      tick(); tick();
      check("rst_if_valid", if_valid, 0);
      check("rst_if_instr", if_instr, NOP);
      check("rst_if_pc", if_pc, 0);
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_pc_stall", pc_stall, 1);

      // Zero-wait stream: 2-cycle fill then one word per cycle
      rst = 1'b1; next_pc = 32'h0;
      tick(); tick();
      check("fill_pc0", if_pc, 32'h0);
      check("fill_instr0", if_instr, 32'hC0DE_0000);
      check("fill_valid0", if_valid, 1);
      tick(); check("fill_pc1", if_pc, 32'h4);
      tick(); check("fill_pc2", if_pc, 32'h8);
      tick(); check("fill_pc3", if_pc, 32'hC);
      repeat (3) tick();
      check("pre_stall_pc", if_pc, 32'h18);

      // Decode stall: response to 0x1C lands in skid, fetch holds
      id_stall = 1'b1;
      tick();
      check("stall_if_pc", if_pc, 32'h18);
      check("stall_mem_req", mem_req, 0);
      check("stall_pc_stall", pc_stall, 1);
      repeat (3) tick();
      id_stall = 1'b0;
      tick();
      check("drain_if_pc", if_pc, 32'h1C);
      check("drain_mem_addr", mem_addr, 32'h20);
      tick();
      check("after_drain_pc", if_pc, 32'h20);

      // Wait states: ack three cycles after each request
      ack_wait = 3;
      repeat (20) tick();
      check("seen_enough", seen_pc.size() >= 12, 1);
      foreach (seen_pc[i]) check("order", seen_pc[i], 32'(4 * i));

      // Flush with a request outstanding; its late response must be dropped
      auto_mem = 0; mem_ack = 1'b0; flush = 1'b1;
      tick();
      check("flush_if_valid", if_valid, 0);
      check("flush_if_instr", if_instr, NOP);
      check("flush_mem_req", mem_req, 1);
      check("flush_mem_addr", mem_addr, 32'h38);
      flush = 1'b0; next_pc = 32'h40;
      tick();
      mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      tick();
      check("discard_mem_req", mem_req, 0);
      check("discard_if_valid", if_valid, 0);
      mem_ack = 1'b0; auto_mem = 1; ack_wait = 0;
      tick();
      check("redirect_addr", mem_addr, 32'h40);
      check("redirect_req", mem_req, 1);
      tick();
      check("redirect_if_pc", if_pc, 32'h40);
      check("redirect_instr", if_instr, 32'hC0DE_0040);

      // Fill the skid, then flush with a coincident ack
      id_stall = 1'b1;
      tick();
      check("skid_fill_pc", if_pc, 32'h40);
      auto_mem = 0; mem_ack = 1'b1; mem_rdata = 32'h0000_1234; flush = 1'b1;
      tick();
      check("fskid_if_valid", if_valid, 0);
      check("fskid_if_instr", if_instr, NOP);
      check("fskid_mem_req", mem_req, 0);
      flush = 1'b0; mem_ack = 1'b0; id_stall = 1'b0; auto_mem = 1; next_pc = 32'h80;
      tick();
      check("fskid_empty", if_valid, 0);
      check("fskid_launch", mem_addr, 32'h80);
      tick();
      check("fskid_restart", if_pc, 32'h80);

      // Flush coincident with a live ack that would load IF/ID
      flush = 1'b1;
      tick();
      check("flush_ack_req", mem_req, 0);
      check("flush_ack_valid", if_valid, 0);
      flush = 1'b0;

      // Reset mid-request, late ack ignored, fetch restarts from pc_in
      auto_mem = 0; mem_ack = 1'b0; next_pc = 32'h100;
      tick();
      check("mid_req_up", mem_req, 1);
      check("mid_req_addr", mem_addr, 32'h100);
      tick();
      rst = 1'b0;
      tick();
      check("mid_rst_req", mem_req, 0);
      check("mid_rst_addr", mem_addr, 0);
      check("mid_rst_valid", if_valid, 0);
      check("mid_rst_instr", if_instr, NOP);
      check("mid_rst_pc", if_pc, 0);
      rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0; next_pc = 32'h200;
      tick();
      check("late_ack_valid", if_valid, 0);
      check("late_ack_req", mem_req, 1);
      check("late_ack_addr", mem_addr, 32'h200);
      mem_ack = 1'b0; auto_mem = 1;
      tick();
      check("restart_pc", if_pc, 32'h200);
      check("restart_instr", if_instr, 32'hC0DE_0200);
      repeat (3) tick();

      check("never_deadbeef", saw_deadbeef, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
